struct_array_sequencer: RTL

Controller that accepts one packed frame of 8 fixed-format records, walks the record index from 0 to 7, and streams the selected records out one at a time over a valid/ready handshake. Each record is {a:1, b:4, c:2}, 7 bits; entry i occupies frame bits [7i+6:7i], with a at bit 7i+6, b at [7i+5:7i+2] and c at [7i+1:7i]. When skipping is enabled, records with a==0 are dropped. The block sits between a frame producer and a per-record consumer, and it owns sequencing of the shared entry-select datapath.

---
 rtl/struct_array_sequencer_pkg.sv | 37 +++
 rtl/struct_array_sequencer_entry_unpacker.sv | 25 ++
 rtl/struct_array_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/struct_array_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// struct_array_pkg
// Shared types and constants for the struct_array_sequencer block.
//   entry_t   : one record {a, b, c} as stored in the packed frame
//   state_t   : sequencer FSM states (IDLE, SCAN, EMIT)
//   N_ENTRIES, B_W, C_W, ENTRY_W, IDX_W, FRAME_W : default geometry
//   entry_is_active() : emission predicate for a single record
// No ports (package).
// ---------------------------------------------------------------------------
package struct_array_pkg;

    localparam int N_ENTRIES = 8;
    localparam int B_W       = 4;
    localparam int C_W       = 2;
    localparam int ENTRY_W   = 1 + B_W + C_W;
    localparam int IDX_W     = $clog2(N_ENTRIES);
    localparam int FRAME_W   = N_ENTRIES * ENTRY_W;

    // Field order matches the frame layout: a is the MSB of each 7-bit slot.
    typedef struct packed {
        logic           a;
        logic [B_W-1:0] b;
        logic [C_W-1:0] c;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2
    } state_t;

    // A record is emitted when its a bit is set, or always when skipping is off.
    function automatic logic entry_is_active(input logic a, input logic skip);
        return a || !skip;
    endfunction

endpackage

// File: rtl/struct_array_sequencer_entry_unpacker.sv
// ---------------------------------------------------------------------------
// entry_unpacker
// Combinational entry-select datapath: picks record idx out of a packed frame
// and presents it as an entry_t.
// Ports:
//   frame  in  FRAME_ENTRIES*ENTRY_W  packed frame, entry i at [7i+6:7i]
//   idx    in  SEL_W                  entry number to select
//   entry  out entry_t                selected record
// ---------------------------------------------------------------------------
module entry_unpacker
    import struct_array_pkg::*;
#(
    parameter int FRAME_ENTRIES = N_ENTRIES,
    parameter int SEL_W         = IDX_W
) (
    input  logic [FRAME_ENTRIES*$bits(entry_t)-1:0] frame,
    input  logic [SEL_W-1:0]                        idx,
    output entry_t                                  entry
);

    localparam int SLOT_W = $bits(entry_t);

    assign entry = frame[int'(idx)*SLOT_W +: SLOT_W];

endmodule

// File: rtl/struct_array_sequencer.sv
// ---------------------------------------------------------------------------
// struct_array_sequencer
// Accepts one packed frame of N_ENTRIES {a,b,c} records, walks the entry
// index from 0 upward and streams the selected records to a consumer.
// With SKIP_INACTIVE=1 only records with a==1 are emitted.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer side (in_*) is accepted only in IDLE; the consumer
// side (out_*) holds every field stable while out_valid=1 and out_ready=0.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   in_valid     in   frame offered
//   in_ready     out  frame can be accepted (IDLE and not in reset)
//   in_data      in   packed frame, N_ENTRIES*ENTRY_W bits
//   out_valid    out  record presented
//   out_ready    in   consumer accepts the record
//   out_index    out  entry number of the presented record
//   out_a/b/c    out  record fields
//   out_last     out  presented record is the last emission of the frame
//   frame_empty  out  one-cycle pulse: the frame held nothing to emit
//   busy         out  a frame is in progress (state != IDLE)
//
// B_W and C_W must match the package entry_t widths.
// ---------------------------------------------------------------------------
module struct_array_sequencer #(
    parameter int N_ENTRIES     = 8,
    parameter int B_W           = 4,
    parameter int C_W           = 2,
    parameter int SKIP_INACTIVE = 1,
    localparam int ENTRY_W      = 1 + B_W + C_W,
    localparam int IDX_W        = $clog2(N_ENTRIES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_ENTRIES*ENTRY_W-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IDX_W-1:0]             out_index,
    output logic                         out_a,
    output logic [B_W-1:0]               out_b,
    output logic [C_W-1:0]               out_c,
    output logic                         out_last,
    output logic                         frame_empty,
    output logic                         busy
);

    import struct_array_pkg::*;

    localparam logic                SKIP     = (SKIP_INACTIVE != 0);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_ENTRIES - 1);

    state_t                       state;
    logic [IDX_W-1:0]             idx;
    logic [N_ENTRIES*ENTRY_W-1:0] frame_q;

    entry_t cur;
    logic   cur_active;
    logic   more_active;

    entry_unpacker #(
        .FRAME_ENTRIES (N_ENTRIES),
        .SEL_W         (IDX_W)
    ) u_unpacker (
        .frame (frame_q),
        .idx   (idx),
        .entry (cur)
    );

    assign cur_active = entry_is_active(cur.a, SKIP);

    // Lookahead for out_last: is any entry above idx still going to be
    // emitted? Only the a bits of frame_q are inspected, so this stays a
    // narrow OR rather than a second copy of the select mux.
    always_comb begin
        more_active = 1'b0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (i > int'(idx) && entry_is_active(frame_q[i*ENTRY_W + ENTRY_W - 1], SKIP)) begin
                more_active = 1'b1;
            end
        end
    end

    assign in_ready    = (state == IDLE) && !rst;
    assign busy        = (state != IDLE);
    // Pulses in the cycle the last entry is scanned and found inactive,
    // i.e. the same cycle the FSM decides to return to IDLE.
    assign frame_empty = !rst && (state == SCAN) && !cur_active && (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            frame_q   <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_a     <= 1'b0;
            out_b     <= '0;
            out_c     <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        frame_q <= in_data;
                        idx     <= '0;
                        state   <= SCAN;
                    end
                end

                SCAN: begin
                    if (cur_active) begin
                        out_valid <= 1'b1;
                        out_index <= idx;
                        out_a     <= cur.a;
                        out_b     <= cur.b;
                        out_c     <= cur.c;
                        out_last  <= !more_active;
                        state     <= EMIT;
                    end else if (idx == LAST_IDX) begin
                        state <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            state <= IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= SCAN;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
